simon_seq_checker: RTL

Player-side checker for the Simon colour sequence. The generator side emits colours from a 2-bit LFSR (x' = {x[0], x[1]^x[0]}, reset state 2'b10). This block is loaded with the round's start state and length, and replays the identical sequence with an internal loadable replica. It compares each debounced button press against the expected colour and reports per-press match, round pass, and round fail (wrong colour or timeout) to the game FSM.

---
 rtl/simon_pkg.sv | 21 ++
 rtl/simon_lfsr_replica.sv | 24 ++
 rtl/simon_seq_checker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon generator and player-side checker.
// Both sides step the colour LFSR through lfsr2_next so their sequences cannot diverge.
package simon_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] BLUE   = 2'b10;
    localparam logic [1:0] YELLOW = 2'b11;

    localparam logic [1:0] LFSR_RESET_STATE = 2'b10;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_BTN = 1'b1
    } state_t;

    function automatic logic [1:0] lfsr2_next(input logic [1:0] x);
        return {x[0], x[1] ^ x[0]};
    endfunction

endpackage

// File: rtl/simon_lfsr_replica.sv
// Loadable copy of the generator LFSR; its state is the colour the player must press next.
module simon_lfsr_replica
    import simon_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] seed,
    input  logic       step,
    output logic [1:0] state
);

    // All-zero is the lock-up state of this LFSR, so it is never allowed in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_RESET_STATE;
        end else if (load) begin
            state <= (seed == 2'b00) ? LFSR_RESET_STATE : seed;
        end else if (step) begin
            state <= lfsr2_next(state);
        end
    end

endmodule

// File: rtl/simon_seq_checker.sv
// Compares debounced presses against the replayed Simon sequence and reports
// registered match / round_pass / round_fail pulses to the game FSM.
module simon_seq_checker
    import simon_pkg::*;
#(
    parameter int LEN_W   = 5,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       seed,
    input  logic [LEN_W-1:0] round_len,
    input  logic             btn_valid,
    input  logic [1:0]       btn_code,
    output logic             busy,
    output logic [1:0]       expect_code,
    output logic [LEN_W-1:0] index,
    output logic             match,
    output logic             round_pass,
    output logic             round_fail,
    output logic             timeout_flag
);

    // With the timeout disabled the counter only needs to avoid wrapping.
    localparam logic [TO_W-1:0] CNT_MAX =
        (TIMEOUT == 0) ? {TO_W{1'b1}} : TO_W'(TIMEOUT - 1);

    state_t           state, state_next;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] index_d, index_inc;
    logic [TO_W-1:0]  count, count_d;
    logic             match_d, pass_d, fail_d, tflag_d;
    logic             load, step;
    logic             press_ok, timeout_hit;

    simon_lfsr_replica u_replica (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .seed  (seed),
        .step  (step),
        .state (expect_code)
    );

    assign press_ok    = btn_valid && (btn_code == expect_code);
    assign timeout_hit = (TIMEOUT != 0) && (count == CNT_MAX);
    assign index_inc   = index + 1'b1;
    assign busy        = (state == WAIT_BTN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (round_len != '0)) begin
                    state_next = WAIT_BTN;
                end
            end
            WAIT_BTN: begin
                if (btn_valid) begin
                    if (!press_ok || (index_inc == len_q)) begin
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A press in the same cycle as the timeout is evaluated; the timeout is dropped.
    always_comb begin
        load    = 1'b0;
        step    = 1'b0;
        len_d   = len_q;
        index_d = index;
        count_d = count;
        match_d = 1'b0;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        tflag_d = timeout_flag;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    len_d   = round_len;
                    index_d = '0;
                    count_d = '0;
                    tflag_d = 1'b0;
                    pass_d  = (round_len == '0);
                end
            end
            WAIT_BTN: begin
                if (btn_valid) begin
                    count_d = '0;
                    if (press_ok) begin
                        step    = 1'b1;
                        match_d = 1'b1;
                        index_d = index_inc;
                        pass_d  = (index_inc == len_q);
                    end else begin
                        fail_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    fail_d  = 1'b1;
                    tflag_d = 1'b1;
                end else if (count != CNT_MAX) begin
                    count_d = count + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            index        <= '0;
            count        <= '0;
            match        <= 1'b0;
            round_pass   <= 1'b0;
            round_fail   <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            len_q        <= len_d;
            index        <= index_d;
            count        <= count_d;
            match        <= match_d;
            round_pass   <= pass_d;
            round_fail   <= fail_d;
            timeout_flag <= tflag_d;
        end
    end

endmodule
